// File: rtl/exp_golomb_pkg.sv
// Shared types and constants for the serial Exp-Golomb decoder.
package exp_golomb_pkg;

  // Width of the decoded sum; prefix zeros plus order never exceed MAX_SUM_BITS-1.
  localparam int MAX_SUM_BITS = 32;

  // Count-field widths: order k, prefix zero count z (0..32), remaining suffix bits r.
  localparam int K_W = 3;
  localparam int Z_W = 6;
  localparam int R_W = 6;

  typedef enum logic [1:0] {
    PREFIX = 2'd0,
    SUFFIX = 2'd1,
    SIGN   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Prefix zero count at which the codeword can no longer fit in MAX_SUM_BITS.
  function automatic logic [Z_W-1:0] overflow_limit(input logic [K_W-1:0] k_i);
    return Z_W'(MAX_SUM_BITS) - Z_W'(k_i);
  endfunction

endpackage

// File: rtl/exp_golomb_decode.sv
// Serial k-th order Exp-Golomb decoder with optional trailing sign bit.
//
// Handshakes: a bit moves when bit_valid && bit_ready at a rising clk edge;
// a result moves when out_valid && out_ready at a rising clk edge. Result
// fields are held constant while out_valid is high and out_ready is low.
module exp_golomb_decode
  import exp_golomb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  k,
  input  logic        is_ac_level,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] val,
  output logic        is_minus,
  output logic [31:0] codeword_length,
  output logic        error,
  output state_t      dbg_state
);

  state_t           r_state, w_state_nxt;
  logic [Z_W-1:0]   r_z, w_z_nxt;
  logic [31:0]      r_acc, w_acc_nxt;
  logic [R_W-1:0]   r_r, w_r_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic             r_ac, w_ac_nxt;
  logic             r_is_minus, w_is_minus_nxt;
  logic             r_err, w_err_nxt;

  logic             w_accept;
  logic             w_first;
  logic [K_W-1:0]   w_k_eff;
  logic             w_ac_eff;
  logic [Z_W-1:0]   w_z_inc;
  logic [R_W-1:0]   w_r_init;

  // The first bit of a codeword is the one accepted in PREFIX with no zeros
  // counted yet; k and is_ac_level are taken live for that bit only.
  assign w_accept = bit_valid && bit_ready;
  assign w_first  = (r_state == PREFIX) && (r_z == '0);
  assign w_k_eff  = w_first ? k : r_k;
  assign w_ac_eff = w_first ? is_ac_level : r_ac;
  assign w_z_inc  = r_z + Z_W'(1);
  assign w_r_init = R_W'(r_z) + R_W'(w_k_eff);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PREFIX;
      r_z        <= '0;
      r_acc      <= '0;
      r_r        <= '0;
      r_k        <= '0;
      r_ac       <= 1'b0;
      r_is_minus <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_z        <= w_z_nxt;
      r_acc      <= w_acc_nxt;
      r_r        <= w_r_nxt;
      r_k        <= w_k_nxt;
      r_ac       <= w_ac_nxt;
      r_is_minus <= w_is_minus_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state and datapath update; every field holds unless a transfer happens.
  always_comb begin
    w_state_nxt    = r_state;
    w_z_nxt        = r_z;
    w_acc_nxt      = r_acc;
    w_r_nxt        = r_r;
    w_k_nxt        = r_k;
    w_ac_nxt       = r_ac;
    w_is_minus_nxt = r_is_minus;
    w_err_nxt      = r_err;
    case (r_state)
      PREFIX: begin
        if (w_accept) begin
          w_k_nxt  = w_k_eff;
          w_ac_nxt = w_ac_eff;
          if (!bit_in) begin
            w_z_nxt = w_z_inc;
            // Too many leading zeros: report an error result of z bits.
            if (w_z_inc == overflow_limit(w_k_eff)) begin
              w_state_nxt = DONE;
              w_err_nxt   = 1'b1;
            end
          end else begin
            w_acc_nxt = 32'd1;
            w_r_nxt   = w_r_init;
            if (w_r_init != '0)  w_state_nxt = SUFFIX;
            else if (w_ac_eff)   w_state_nxt = SIGN;
            else                 w_state_nxt = DONE;
          end
        end
      end
      SUFFIX: begin
        if (w_accept) begin
          w_acc_nxt = {r_acc[30:0], bit_in};
          w_r_nxt   = r_r - R_W'(1);
          if (r_r == R_W'(1)) w_state_nxt = r_ac ? SIGN : DONE;
        end
      end
      SIGN: begin
        if (w_accept) begin
          w_is_minus_nxt = bit_in;
          w_state_nxt    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt    = PREFIX;
          w_z_nxt        = '0;
          w_acc_nxt      = '0;
          w_r_nxt        = '0;
          w_is_minus_nxt = 1'b0;
          w_err_nxt      = 1'b0;
        end
      end
      default: w_state_nxt = PREFIX;
    endcase
  end

  // Result fields are derived from held registers, so they stay stable in DONE.
  always_comb begin
    bit_ready       = (r_state != DONE);
    out_valid       = (r_state == DONE);
    val             = '0;
    is_minus        = 1'b0;
    codeword_length = '0;
    error           = 1'b0;
    if (r_state == DONE) begin
      error    = r_err;
      is_minus = r_is_minus;
      if (r_err) begin
        codeword_length = 32'(r_z);
      end else begin
        val             = r_acc - (32'd1 << r_k);
        codeword_length = (32'(r_z) << 1) + 32'(r_k) + 32'd1 + 32'(r_ac);
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_exp_golomb_decode.sv
// Bench for exp_golomb_decode: an encoder model builds codewords from chosen
// values; the decoder must recover those values.
module tb_exp_golomb_decode;
  import exp_golomb_pkg::*;

  // Clock and reset
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  k;
  logic        is_ac_level;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val;
  logic        is_minus;
  logic [31:0] codeword_length;
  logic        error;
  state_t      dbg_state;

  always #5 clk = ~clk;

  exp_golomb_decode dut (
    .clk(clk), .reset(reset), .k(k), .is_ac_level(is_ac_level),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .out_valid(out_valid), .out_ready(out_ready), .val(val),
    .is_minus(is_minus), .codeword_length(codeword_length),
    .error(error), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: bit stream to send, and expected {error, is_minus, length, val}.
  logic        tx_q[$];
  logic [65:0] exp_q[$];

  // Encoder model: x = val + 2^k written in binary with (bits(x)-1-k) leading zeros.
  task automatic encode(input logic [2:0] kk, input logic ac, input logic [31:0] v, input logic s);
    longint x;
    int     nb;
    x  = longint'(v) + (longint'(1) << kk);
    nb = 0;
    for (longint t = x; t != 0; t = t >> 1) nb++;
    tx_q.delete();
    for (int i = 0; i < nb - 1 - int'(kk); i++) tx_q.push_back(1'b0);
    for (int b = nb - 1; b >= 0; b--) tx_q.push_back(x[b]);
    if (ac) tx_q.push_back(s);
    exp_q.push_back({1'b0, ac ? s : 1'b0, 32'(tx_q.size()), v});
  endtask

  // Driver: send tx_q with random bit_valid gaps; k/ac scrambled after the first bit.
  task automatic send_bits(input logic [2:0] kk, input logic ac);
    int n;
    for (int i = 0; i < tx_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      if (i == 0) begin
        k           = kk;
        is_ac_level = ac;
      end
      if (i == tx_q.size() - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL early_valid: out_valid=%b required 0", out_valid);
        else n_pass++;
      end
      bit_in    = tx_q[i];
      bit_valid = 1'b1;
      n = 0;
      while (bit_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (n >= 50) $display("FAIL ready_timeout: bit_ready=%b required 1 within 50 cycles", bit_ready);
      else n_pass++;
      @(negedge clk);
      bit_valid = 1'b0;
      if (i == 0) begin
        k           = 3'($urandom);
        is_ac_level = 1'($urandom);
      end
    end
  endtask

  // Check the result one cycle after the final bit, hold it, then accept it.
  task automatic finish_codeword(input int hold);
    logic [65:0] e;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL latency: out_valid=%b required 1", out_valid);
    else n_pass++;
    n_checks++;
    if (val !== e[31:0]) $display("FAIL val: got %0d required %0d", val, e[31:0]);
    else n_pass++;
    n_checks++;
    if (codeword_length !== e[63:32]) $display("FAIL length: got %0d required %0d", codeword_length, e[63:32]);
    else n_pass++;
    n_checks++;
    if (is_minus !== e[64]) $display("FAIL is_minus: got %b required %b", is_minus, e[64]);
    else n_pass++;
    n_checks++;
    if (error !== e[65]) $display("FAIL error: got %b required %b", error, e[65]);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || bit_ready !== 1'b0)
        $display("FAIL hold_ctrl: out_valid=%b bit_ready=%b required 1/0", out_valid, bit_ready);
      else n_pass++;
      n_checks++;
      if ({error, is_minus, codeword_length, val} !== e)
        $display("FAIL hold_data: got %h required %h", {error, is_minus, codeword_length, val}, e);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || bit_ready !== 1'b1)
      $display("FAIL release: out_valid=%b bit_ready=%b required 0/1", out_valid, bit_ready);
    else n_pass++;
  endtask

  task automatic run_cw(input logic [2:0] kk, input logic ac, input logic [31:0] v,
                        input logic s, input int hold);
    encode(kk, ac, v, s);
    send_bits(kk, ac);
    finish_codeword(hold);
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    k = 3'd0; is_ac_level = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || val !== 32'd0 || codeword_length !== 32'd0 || error !== 1'b0 || is_minus !== 1'b0)
      $display("FAIL reset_outputs: valid=%b val=%0d len=%0d err=%b minus=%b required all 0",
               out_valid, val, codeword_length, error, is_minus);
    else n_pass++;
    n_checks++;
    if (bit_ready !== 1'b1 || dbg_state !== PREFIX)
      $display("FAIL reset_ready: bit_ready=%b state=%0d required 1/PREFIX", bit_ready, dbg_state);
    else n_pass++;
  endtask

  task automatic test_vectors();
    run_cw(3'd0, 1'b0, 32'd0, 1'b0, 0);  // "1"
    run_cw(3'd2, 1'b0, 32'd5, 1'b0, 0);  // "01001"
    run_cw(3'd0, 1'b0, 32'd1, 1'b0, 0);  // "010"
    run_cw(3'd0, 1'b1, 32'd3, 1'b1, 0);  // "001001"
  endtask

  task automatic test_stall();
    run_cw(3'd1, 1'b1, 32'd6, 1'b0, 3);
    run_cw(3'd0, 1'b0, 32'd0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    tx_q.push_back(1'b0); tx_q.push_back(1'b1);
    tx_q.push_back(1'b1); tx_q.push_back(1'b0);
    send_bits(3'd2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || bit_ready !== 1'b1 || codeword_length !== 32'd0)
        $display("FAIL reset_mid: out_valid=%b bit_ready=%b len=%0d required 0/1/0",
                 out_valid, bit_ready, codeword_length);
      else n_pass++;
      @(negedge clk);
    end
    run_cw(3'd0, 1'b0, 32'd1, 1'b0, 0);
  endtask

  task automatic test_overflow(input logic [2:0] kk);
    tx_q.delete();
    for (int i = 0; i < 32 - int'(kk); i++) tx_q.push_back(1'b0);
    exp_q.push_back({1'b1, 1'b0, 32'(32 - int'(kk)), 32'd0});
    send_bits(kk, 1'b1);
    finish_codeword(1);
  endtask

  task automatic test_random(input int count, input int max_hold);
    logic [2:0] kk;
    int         nb;
    longint     x;
    for (int t = 0; t < count; t++) begin
      kk = 3'($urandom);
      if ($urandom_range(0, 7) == 0) nb = 32;
      else nb = $urandom_range(int'(kk) + 1, int'(kk) + 10);
      x = (longint'(1) << (nb - 1)) |
          ({longint'($urandom), longint'($urandom)} & ((longint'(1) << (nb - 1)) - 1));
      run_cw(kk, 1'($urandom), 32'(x - (longint'(1) << kk)), 1'($urandom),
             $urandom_range(0, max_hold));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_overflow(3'd0);
    test_overflow(3'd7);
    test_random(40, 2);
    test_random(10, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
